// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM weight ping-pong buffer.
package gemm_pkg;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LOAD = 2'd1,
    L_FULL = 2'd2
  } load_state_e;

  typedef enum logic {
    R_EMPTY  = 1'b0,
    R_ACTIVE = 1'b1
  } rd_state_e;

  // Callers zero-extend words into this width; zero padding leaves the parity unchanged.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/gemm_wbuf_bank.sv
// One weight bank: simple dual-port RAM, single write port, synchronous read with one-cycle latency.
module gemm_wbuf_bank #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/gemm_w_buff_pp.sv
// Ping-pong weight buffer: the shadow bank loads one row per beat while the active bank streams cyclic passes.
// Optional per-word even parity with sticky error flag: define GEMM_WBUF_PARITY_EN.
module gemm_w_buff_pp
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 512,
  parameter int N_COLS     = 8,
  parameter int N_DEPTH    = $clog2(DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_load_start,
  input  logic [N_DEPTH:0]             i_load_len,
  input  logic                         i_wr_valid,
  output logic                         o_wr_ready,
  input  logic [N_COLS*DATA_WIDTH-1:0] i_wr_data,
  output logic                         o_shadow_full,
  input  logic                         i_swap,
  input  logic                         i_rd_en,
  output logic                         o_rd_valid,
  output logic [N_COLS*DATA_WIDTH-1:0] o_rd_data,
  output logic                         o_rd_last,
  output logic                         o_pass_done,
  output logic                         o_par_err
);

  localparam int ROW_W = N_COLS * DATA_WIDTH;
`ifdef GEMM_WBUF_PARITY_EN
  localparam int BANK_W = ROW_W + N_COLS;
`else
  localparam int BANK_W = ROW_W;
`endif
  localparam logic [N_DEPTH:0]   LEN_ONE = (N_DEPTH+1)'(1);
  localparam logic [N_DEPTH:0]   LEN_MAX = (N_DEPTH+1)'(DEPTH);
  localparam logic [N_DEPTH-1:0] PTR_ONE = N_DEPTH'(1);

  load_state_e        load_q;
  rd_state_e          rd_q;
  logic               bank_sel_q;
  logic [N_DEPTH:0]   len_q, active_len_q;
  logic [N_DEPTH-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d, rd_addr;
  logic               pass_done_q;

  logic swap_acc, start_ok, wr_fire, wr_last, consume, rd_is_last;
  logic [BANK_W-1:0] wr_word, rdata0, rdata1, rdata_act;

  assign swap_acc   = i_swap && (load_q == L_FULL);
  assign start_ok   = i_load_start && (i_load_len != '0);
  assign wr_fire    = i_wr_valid && (load_q == L_LOAD);
  assign wr_last    = ({1'b0, wr_ptr_q} == len_q - LEN_ONE);
  assign consume    = (rd_q == R_ACTIVE) && i_rd_en && !swap_acc;
  assign rd_is_last = ({1'b0, rd_ptr_q} == active_len_q - LEN_ONE);
  assign rd_ptr_d   = rd_is_last ? '0 : rd_ptr_q + PTR_ONE;
  // Address runs one cycle ahead of rd_ptr so a new row is available every cycle.
  assign rd_addr    = swap_acc ? '0 : (consume ? rd_ptr_d : rd_ptr_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      load_q       <= L_IDLE;
      rd_q         <= R_EMPTY;
      bank_sel_q   <= 1'b0;
      len_q        <= '0;
      active_len_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pass_done_q  <= 1'b0;
    end else begin
      pass_done_q <= consume && rd_is_last;
      if (swap_acc) begin
        bank_sel_q   <= ~bank_sel_q;
        active_len_q <= len_q;
        rd_ptr_q     <= '0;
        rd_q         <= R_ACTIVE;
      end else if (consume) begin
        rd_ptr_q <= rd_ptr_d;
      end
      // A start in the swap cycle targets the freshly freed bank.
      if (start_ok) begin
        len_q    <= (i_load_len > LEN_MAX) ? LEN_MAX : i_load_len;
        wr_ptr_q <= '0;
        load_q   <= L_LOAD;
      end else if (swap_acc) begin
        load_q <= L_IDLE;
      end else if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (wr_last) load_q <= L_FULL;
      end
    end
  end

`ifdef GEMM_WBUF_PARITY_EN
  logic [N_COLS-1:0] wr_par, rd_par_bad;
  logic              par_err_q;

  always_comb begin
    wr_par     = '0;
    rd_par_bad = '0;
    for (int c = 0; c < N_COLS; c++) begin
      wr_par[c]     = even_par(PAR_MAX_W'(i_wr_data[c*DATA_WIDTH +: DATA_WIDTH]));
      rd_par_bad[c] = even_par(PAR_MAX_W'(rdata_act[c*DATA_WIDTH +: DATA_WIDTH])) != rdata_act[ROW_W+c];
    end
  end

  assign wr_word = {wr_par, i_wr_data};

  always_ff @(posedge i_clk) begin
    if (i_rst)                            par_err_q <= 1'b0;
    else if (o_rd_valid && |rd_par_bad)   par_err_q <= 1'b1;
  end

  assign o_par_err = par_err_q;
`else
  assign wr_word   = i_wr_data;
  assign o_par_err = 1'b0;
`endif

  gemm_wbuf_bank #(.WIDTH(BANK_W), .DEPTH(DEPTH), .AW(N_DEPTH)) u_bank0 (
    .i_clk   (i_clk),
    .i_we    (wr_fire && bank_sel_q),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_word),
    .i_raddr (rd_addr),
    .o_rdata (rdata0)
  );

  gemm_wbuf_bank #(.WIDTH(BANK_W), .DEPTH(DEPTH), .AW(N_DEPTH)) u_bank1 (
    .i_clk   (i_clk),
    .i_we    (wr_fire && !bank_sel_q),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_word),
    .i_raddr (rd_addr),
    .o_rdata (rdata1)
  );

  assign rdata_act     = bank_sel_q ? rdata1 : rdata0;
  assign o_wr_ready    = (load_q == L_LOAD);
  assign o_shadow_full = (load_q == L_FULL);
  assign o_rd_valid    = (rd_q == R_ACTIVE);
  assign o_rd_data     = o_rd_valid ? rdata_act[ROW_W-1:0] : '0;
  assign o_rd_last     = o_rd_valid && rd_is_last;
  assign o_pass_done   = pass_done_q;

endmodule

// File: tb/tb_gemm_w_buff_pp.sv
// Self-checking bench for gemm_w_buff_pp: queue-based bank model compared every cycle plus directed literal checks.
module tb_gemm_w_buff_pp;

  localparam int DW    = 16;
  localparam int DEPTH = 512;
  localparam int NC    = 8;
  localparam int ND    = $clog2(DEPTH);
  localparam int LW    = ND + 1;
  localparam int RW    = NC * DW;

  logic          i_clk, i_rst, i_load_start, i_wr_valid, i_swap, i_rd_en;
  logic [LW-1:0] i_load_len;
  logic [RW-1:0] i_wr_data, o_rd_data;
  logic          o_wr_ready, o_shadow_full, o_rd_valid, o_rd_last, o_pass_done, o_par_err;

  gemm_w_buff_pp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .N_COLS(NC)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load_start(i_load_start), .i_load_len(i_load_len),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_shadow_full(o_shadow_full), .i_swap(i_swap), .i_rd_en(i_rd_en),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .o_pass_done(o_pass_done), .o_par_err(o_par_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int v, input bit mix);
    logic [RW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*DW +: DW] = DW'(v) ^ (mix ? DW'(c << 12) : DW'(0));
    return r;
  endfunction

  // Model: shadow set as a queue of rows, active set as a copied queue plus a row index.
  logic [RW-1:0] sh[$];
  logic [RW-1:0] act[$];
  bit m_load, m_full, m_valid, m_pd, started;
  int m_idx, m_len;

  always @(posedge i_clk) begin : mdl
    bit swap_ok, cons, was_load;
    started = 1'b1;
    if (i_rst) begin
      m_load = 0; m_full = 0; m_valid = 0; m_pd = 0; m_idx = 0;
      sh.delete(); act.delete();
    end else begin
      was_load = m_load;
      swap_ok  = i_swap && m_full;
      cons     = m_valid && i_rd_en && !swap_ok;
      m_pd     = 0;
      if (cons) begin
        if (m_idx == act.size() - 1) begin m_pd = 1; m_idx = 0; end
        else m_idx++;
      end
      if (swap_ok) begin
        act = sh; m_idx = 0; m_valid = 1; m_full = 0;
      end
      if (i_load_start && i_load_len != 0) begin
        sh.delete();
        m_len  = (int'(i_load_len) > DEPTH) ? DEPTH : int'(i_load_len);
        m_load = 1; m_full = 0;
      end else if (was_load && i_wr_valid) begin
        sh.push_back(i_wr_data);
        if (sh.size() == m_len) begin m_load = 0; m_full = 1; end
      end
    end
  end

  always @(negedge i_clk) begin
    if (started) begin
      chk("wr_ready",    RW'(o_wr_ready),    RW'(m_load));
      chk("shadow_full", RW'(o_shadow_full), RW'(m_full));
      chk("rd_valid",    RW'(o_rd_valid),    RW'(m_valid));
      chk("rd_data",     o_rd_data,          m_valid ? act[m_idx] : '0);
      chk("rd_last",     RW'(o_rd_last),     RW'(m_valid && (m_idx == act.size() - 1)));
      chk("pass_done",   RW'(o_pass_done),   RW'(m_pd));
`ifndef GEMM_WBUF_PARITY_EN
      chk("par_err",     RW'(o_par_err),     '0);
`endif
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_load(input int len);
    i_load_start = 1'b1; i_load_len = LW'(len);
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic beats(input int n, input int base, input bit mix);
    for (int k = 0; k < n; k++) begin
      i_wr_valid = 1'b1; i_wr_data = mkrow(base + k, mix);
      tick();
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic do_swap();
    i_swap = 1'b1;
    tick();
    i_swap = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_wr_ready"},  RW'(o_wr_ready),    '0);
    chk({nm, "_full"},      RW'(o_shadow_full), '0);
    chk({nm, "_rd_valid"},  RW'(o_rd_valid),    '0);
    chk({nm, "_rd_last"},   RW'(o_rd_last),     '0);
    chk({nm, "_pass_done"}, RW'(o_pass_done),   '0);
    chk({nm, "_par_err"},   RW'(o_par_err),     '0);
    chk({nm, "_rd_data"},   o_rd_data,          '0);
  endtask

  int acc;

  initial begin
    i_rst = 1'b1; i_load_start = 1'b0; i_load_len = '0; i_wr_valid = 1'b0;
    i_wr_data = '0; i_swap = 1'b0; i_rd_en = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    chk_all_zero("reset");

    // Basic pass of four identical-column rows
    start_load(4);
    beats(4, 1, 1'b0);
    chk("t1_full", RW'(o_shadow_full), RW'(1));
    i_rd_en = 1'b1;
    do_swap();
    chk("t1_valid", RW'(o_rd_valid), RW'(1));
    chk("t1_row1",  o_rd_data, {NC{16'h0001}});
    tick(); chk("t1_row2", o_rd_data, {NC{16'h0002}});
    tick(); chk("t1_row3", o_rd_data, {NC{16'h0003}});
    tick(); chk("t1_row4", o_rd_data, {NC{16'h0004}});
    chk("t1_last", RW'(o_rd_last), RW'(1));
    tick(); chk("t1_wrap", o_rd_data, {NC{16'h0001}});
    chk("t1_pdone", RW'(o_pass_done), RW'(1));
    chk("t1_last0", RW'(o_rd_last), RW'(0));
    repeat (3) tick();

    // Load while streaming, swap mid-pass
    start_load(3);
    beats(3, 'h11, 1'b1);
    do_swap();
    chk("t2_a0", o_rd_data, mkrow('h11, 1'b1));
    repeat (4) tick();
    start_load(5);
    beats(5, 'h21, 1'b1);
    tick();
    do_swap();
    chk("t2_b0", o_rd_data, mkrow('h21, 1'b1));
    repeat (12) tick();

    // Swap during a partial load is ignored
    start_load(4);
    beats(2, 'h31, 1'b1);
    do_swap();
    chk("t3_notfull", RW'(o_shadow_full), RW'(0));
    chk("t3_loading", RW'(o_wr_ready),    RW'(1));
    beats(2, 'h33, 1'b1);
    chk("t3_full", RW'(o_shadow_full), RW'(1));

    // Zero-length start is ignored
    start_load(0);
    chk("t4_len0_full", RW'(o_shadow_full), RW'(1));
    chk("t4_len0_rdy",  RW'(o_wr_ready),    RW'(0));

    // Swap and start together: swap first, new load into freed bank
    i_swap = 1'b1; i_load_start = 1'b1; i_load_len = LW'(2);
    tick();
    i_swap = 1'b0; i_load_start = 1'b0;
    chk("t4_sim_rdy",  RW'(o_wr_ready), RW'(1));
    chk("t4_sim_row",  o_rd_data, mkrow('h31, 1'b1));
    beats(1, 'h41, 1'b1);

    // Oversized length clamps to DEPTH; also restarts the partial load
    start_load(DEPTH + 10);
    acc = 0;
    i_wr_valid = 1'b1;
    for (int k = 0; k < DEPTH + 20; k++) begin
      i_wr_data = mkrow('h100 + acc, 1'b1);
      if (o_wr_ready) acc++;
      tick();
    end
    i_wr_valid = 1'b0;
    chk("t4_beats", RW'(acc), RW'(DEPTH));
    chk("t4_full",  RW'(o_shadow_full), RW'(1));
    do_swap();
    repeat (DEPTH + 8) tick();

    // Reset during a load and a pass
    start_load(4);
    beats(2, 'h51, 1'b1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_all_zero("t5_rst");
    do_swap();
    chk("t5_swap_ign", RW'(o_rd_valid), RW'(0));
    start_load(2);
    beats(2, 'h61, 1'b1);
    do_swap();
    chk("t5_valid", RW'(o_rd_valid), RW'(1));
    chk("t5_row0",  o_rd_data, mkrow('h61, 1'b1));
    repeat (4) tick();

`ifdef GEMM_WBUF_PARITY_EN
    // Flip column 3 parity bit of row 1 in the bank that becomes active after reset
    i_rst = 1'b1; i_rd_en = 1'b0;
    tick();
    i_rst = 1'b0;
    start_load(3);
    beats(3, 'h71, 1'b1);
    u_dut.u_bank1.mem_q[1][RW+3] = ~u_dut.u_bank1.mem_q[1][RW+3];
    do_swap();
    chk("par_row0", RW'(o_par_err), RW'(0));
    i_rd_en = 1'b1;
    tick();
    chk("par_row1_pre", RW'(o_par_err), RW'(0));
    tick();
    chk("par_set", RW'(o_par_err), RW'(1));
    repeat (3) tick();
    chk("par_sticky", RW'(o_par_err), RW'(1));
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("par_clr", RW'(o_par_err), RW'(0));
`endif

    i_rd_en = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
